// File: rtl/decryption_reg_arbiter_if.sv
// Requester-side handshake bundle for the decryption register arbiter.
// The requester drives the master modport; the arbiter uses the slave modport.
interface decryption_reg_arbiter_if #(
    parameter int addr_width = 8,
    parameter int reg_width  = 16
);
    logic                  valid;
    logic                  write;
    logic [addr_width-1:0] addr;
    logic [reg_width-1:0]  wdata;
    logic                  ready;
    logic                  done;

    modport master (
        output valid, write, addr, wdata,
        input  ready, done
    );

    modport slave (
        input  valid, write, addr, wdata,
        output ready, done
    );
endinterface

// File: rtl/decryption_reg_arbiter.sv
// Round-robin arbiter sharing one decryption register-file port between two requesters,
// with a single outstanding transaction and a WAIT-state timeout.
module decryption_reg_arbiter #(
    parameter int addr_width = 8,
    parameter int reg_width  = 16,
    parameter int TIMEOUT    = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    decryption_reg_arbiter_if.slave req0_if,
    decryption_reg_arbiter_if.slave req1_if,
    output logic [reg_width-1:0]   rsp_rdata_o,
    output logic                   rsp_error_o,
    output logic [addr_width-1:0]  reg_addr_o,
    output logic [reg_width-1:0]   reg_wdata_o,
    output logic                   reg_read_o,
    output logic                   reg_write_o,
    input  logic [reg_width-1:0]   reg_rdata_i,
    input  logic                   reg_done_i,
    input  logic                   reg_error_i,
    output logic                   busy_o
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic                  write_q, write_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [reg_width-1:0]  wdata_q, wdata_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [reg_width-1:0]  rdata_q, rdata_d;
    logic                  error_q, error_d;

    logic                  any_valid;
    logic                  arb_grant;

    // On a tie the port that did not win last time is chosen; a lone requester always wins.
    assign any_valid = req0_if.valid | req1_if.valid;
    assign arb_grant = (req0_if.valid && req1_if.valid) ? ~last_grant_q : ~req0_if.valid;

    assign req0_if.ready = (state_q == IDLE) && any_valid && !arb_grant;
    assign req1_if.ready = (state_q == IDLE) && any_valid &&  arb_grant;
    assign req0_if.done  = (state_q == RESP) && !grant_q;
    assign req1_if.done  = (state_q == RESP) &&  grant_q;

    assign reg_read_o  = (state_q == ISSUE) && !write_q;
    assign reg_write_o = (state_q == ISSUE) &&  write_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign rsp_rdata_o = rdata_q;
    assign rsp_error_o = error_q;
    assign busy_o      = (state_q != IDLE);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        timer_d      = timer_q;
        rdata_d      = rdata_q;
        error_d      = error_q;

        case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d      = arb_grant;
                    last_grant_d = arb_grant;
                    write_d      = arb_grant ? req1_if.write : req0_if.write;
                    addr_d       = arb_grant ? req1_if.addr  : req0_if.addr;
                    wdata_d      = arb_grant ? req1_if.wdata : req0_if.wdata;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion arriving in the final timeout cycle still wins.
                if (reg_done_i) begin
                    rdata_d = reg_rdata_i;
                    error_d = reg_error_i;
                    state_d = RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    error_d = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            timer_q      <= '0;
            rdata_q      <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            timer_q      <= timer_d;
            rdata_q      <= rdata_d;
            error_q      <= error_d;
        end
    end

endmodule

// File: tb/tb_decryption_reg_arbiter.sv
// Randomized self-checking bench for decryption_reg_arbiter; a transaction-level model
// predicts the winner, strobe, response cycle and response data for each request.
module tb_decryption_reg_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] rspRdata;
    logic          rspError;
    logic [AW-1:0] regAddr;
    logic [DW-1:0] regWdata;
    logic          regRead;
    logic          regWrite;
    logic [DW-1:0] regRdata = '0;
    logic          regDone = 1'b0;
    logic          regError = 1'b0;
    logic          busy;

    int checkCount = 0;
    int errorCount = 0;
    bit lastGrant = 1'b1;

    decryption_reg_arbiter_if #(.addr_width(AW), .reg_width(DW)) req0If ();
    decryption_reg_arbiter_if #(.addr_width(AW), .reg_width(DW)) req1If ();

    decryption_reg_arbiter #(
        .addr_width(AW),
        .reg_width (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_if    (req0If),
        .req1_if    (req1If),
        .rsp_rdata_o(rspRdata),
        .rsp_error_o(rspError),
        .reg_addr_o (regAddr),
        .reg_wdata_o(regWdata),
        .reg_read_o (regRead),
        .reg_write_o(regWrite),
        .reg_rdata_i(regRdata),
        .reg_done_i (regDone),
        .reg_error_i(regError),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Both readies high at once would let two requesters believe they were accepted.
    always @(negedge clk) begin
        if (rst_n) checkOutput("oneReady", 32'(req0If.ready & req1If.ready), 32'd0);
    end

    // One complete transaction. d is the WAIT cycle (1-based) in which the slave pulses
    // reg_done; d > TO models a slave that answers only after the timeout has fired.
    task automatic applyStimulus(input bit v0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input bit v1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                 input int d, input bit sErr, input logic [DW-1:0] sRd);
        bit            win;
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] expRd;
        bit            expErr;
        int            nWait;

        win = (v0 && v1) ? !lastGrant : !v0;
        w   = win ? w1 : w0;
        a   = win ? a1 : a0;
        wd  = win ? d1 : d0;
        nWait  = (d <= TO) ? d : TO;
        expRd  = (d <= TO) ? sRd : '0;
        expErr = (d <= TO) ? sErr : 1'b1;

        req0If.valid = v0; req0If.write = w0; req0If.addr = a0; req0If.wdata = d0;
        req1If.valid = v1; req1If.write = w1; req1If.addr = a1; req1If.wdata = d1;
        #1;
        checkOutput("idleBusy", 32'(busy), 32'd0);
        checkOutput("ready0", 32'(req0If.ready), 32'(!win));
        checkOutput("ready1", 32'(req1If.ready), 32'(win));
        lastGrant = win;

        @(posedge clk); #1;
        req0If.valid = 1'b0;
        req1If.valid = 1'b0;
        checkOutput("issueRead", 32'(regRead), 32'(!w));
        checkOutput("issueWrite", 32'(regWrite), 32'(w));
        checkOutput("issueAddr", 32'(regAddr), 32'(a));
        if (w) checkOutput("issueWdata", 32'(regWdata), 32'(wd));
        checkOutput("issueBusy", 32'(busy), 32'd1);

        for (int k = 1; k <= nWait; k++) begin
            @(posedge clk); #1;
            checkOutput("waitStrobe", 32'({regRead, regWrite}), 32'd0);
            checkOutput("waitDone", 32'({req0If.done, req1If.done}), 32'd0);
            checkOutput("waitAddr", 32'(regAddr), 32'(a));
            if (k == d) begin
                regDone  = 1'b1;
                regRdata = sRd;
                regError = sErr;
            end
        end

        @(posedge clk); #1;
        regDone  = 1'b0;
        regError = 1'b0;
        regRdata = '0;
        checkOutput("respDone0", 32'(req0If.done), 32'(!win));
        checkOutput("respDone1", 32'(req1If.done), 32'(win));
        checkOutput("respRdata", 32'(rspRdata), 32'(expRd));
        checkOutput("respError", 32'(rspError), 32'(expErr));
        if (d > TO) begin
            regDone  = 1'b1;
            regRdata = 16'hDEAD;
        end

        @(posedge clk); #1;
        regDone  = 1'b0;
        regRdata = '0;
        checkOutput("idleNoDone", 32'({req0If.done, req1If.done}), 32'd0);
        checkOutput("idleBusyAfter", 32'(busy), 32'd0);
        checkOutput("holdRdata", 32'(rspRdata), 32'(expRd));
        checkOutput("holdError", 32'(rspError), 32'(expErr));
    endtask

    initial begin
        bit            rv0, rv1, rw0, rw1, rErr;
        logic [AW-1:0] ra0, ra1;
        logic [DW-1:0] rd0, rd1, rRd;
        int            rDelay;
        int            pat;

        req0If.valid = 1'b0; req0If.write = 1'b0; req0If.addr = '0; req0If.wdata = '0;
        req1If.valid = 1'b0; req1If.write = 1'b0; req1If.addr = '0; req1If.wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstStrobe", 32'({regRead, regWrite}), 32'd0);
        checkOutput("rstDone", 32'({req0If.done, req1If.done}), 32'd0);
        checkOutput("rstRsp", 32'({rspError, rspRdata}), 32'd0);
        checkOutput("rstAddr", 32'(regAddr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lastGrant = 1'b1;
        @(posedge clk); #1;

        // Four ties straight after reset: round robin starting at port 0.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b1, 1'b0, 8'(8'h20 + i), 16'h0, 1'b1, 1'b1, 8'(8'h30 + i), 16'(16'h1000 + i),
                          1 + i, 1'b0, 16'(16'h0A00 + i));

        applyStimulus(1'b1, 1'b1, 8'h10, 16'h0003, 1'b0, 1'b0, 8'h00, 16'h0, 2, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h14, 16'h0, 2, 1'b0, 16'h0002);
        applyStimulus(1'b1, 1'b0, 8'h55, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, 3, 1'b1, 16'h0000);
        applyStimulus(1'b1, 1'b0, 8'h60, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, TO + 2, 1'b0, 16'h1234);
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0, 8'h61, 16'h0, TO, 1'b0, 16'hBEEF);
        applyStimulus(1'b1, 1'b1, 8'h62, 16'h5A5A, 1'b0, 1'b0, 8'h00, 16'h0, 1, 1'b0, 16'h0000);

        for (int i = 0; i < 24; i++) begin
            pat = $urandom_range(1, 3);
            rv0 = pat[0];
            rv1 = pat[1];
            rw0 = 1'($urandom_range(0, 1));
            rw1 = 1'($urandom_range(0, 1));
            ra0 = 8'($urandom);
            ra1 = 8'($urandom);
            rd0 = 16'($urandom);
            rd1 = 16'($urandom);
            rErr = ($urandom_range(0, 3) == 0);
            rRd  = 16'($urandom);
            rDelay = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(1, 3) : $urandom_range(1, 5);
            applyStimulus(rv0, rw0, ra0, rd0, rv1, rw1, ra1, rd1, rDelay, rErr, rRd);
        end

        // Abort a port 0 read in WAIT with an asynchronous reset.
        req0If.valid = 1'b1; req0If.write = 1'b0; req0If.addr = 8'h22;
        @(posedge clk); #1;
        req0If.valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("abortBusyBefore", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortStrobe", 32'({regRead, regWrite}), 32'd0);
        checkOutput("abortDone", 32'({req0If.done, req1If.done}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lastGrant = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b0, 8'h22, 16'h0, 1'b1, 1'b1, 8'h23, 16'h7777, 2, 1'b0, 16'h0042);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
